// File: rtl/tmip_xcorr_engine_pkg.sv
// tmip_pkg: shared constants and types for the TMIP cross-correlation engine.
// Holds the image-size selector encoding, the control FSM state type and a
// helper that derives the default serialised result width from PIX_W.
package tmip_pkg;

  // image_size selector encoding (side = 4 << code)
  localparam logic [1:0] SZ_4  = 2'd0;
  localparam logic [1:0] SZ_8  = 2'd1;
  localparam logic [1:0] SZ_16 = 2'd2;
  localparam logic [1:0] SZ_32 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } tmip_state_t;

  // Nine PIX_W x PIX_W products need 2*PIX_W + 4 bits to never overflow.
  function automatic int tmip_out_w(input int pix_w);
    return 32'sd2 * pix_w + 32'sd4;
  endfunction

endpackage

// File: rtl/tmip_xcorr_engine_mac9.sv
// tmip_mac9: combinational 3x3 multiply-accumulate for one correlation result.
// Pixels are unsigned and gated by their padding mask. Coefficients are
// unsigned, or two's-complement when TMIP_XCORR_SIGNED_TPL_EN is defined.
// All arithmetic is done modulo 2^OUT_W, which is exact in both modes
// because the true result always fits in OUT_W bits.
module tmip_mac9 #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 20
) (
  input  logic [9*PIX_W-1:0] i_pix,
  input  logic [8:0]         i_mask,
  input  logic [9*PIX_W-1:0] i_coef,
  output logic [OUT_W-1:0]   o_sum
);

  logic [OUT_W-1:0] w_px [9];
  logic [OUT_W-1:0] w_cf [9];

  // Widen every tap to OUT_W: masked pixels zero-extended, coefficients extended per mode
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_px[k] = {OUT_W{1'b0}};
      w_cf[k] = {OUT_W{1'b0}};
      if (i_mask[k]) begin
        w_px[k] = {{(OUT_W-PIX_W){1'b0}}, i_pix[k*PIX_W +: PIX_W]};
      end else begin
        w_px[k] = {OUT_W{1'b0}};
      end
`ifdef TMIP_XCORR_SIGNED_TPL_EN
      w_cf[k] = {{(OUT_W-PIX_W){i_coef[k*PIX_W+PIX_W-1]}}, i_coef[k*PIX_W +: PIX_W]};
`else
      w_cf[k] = {{(OUT_W-PIX_W){1'b0}}, i_coef[k*PIX_W +: PIX_W]};
`endif
    end
  end

  // Sum of the nine products
  always_comb begin
    o_sum = {OUT_W{1'b0}};
    for (int k = 0; k < 9; k++) begin
      o_sum = o_sum + w_px[k] * w_cf[k];
    end
  end

endmodule

// File: rtl/tmip_xcorr_engine.sv
// tmip_xcorr_engine: zero-padded 3x3 cross-correlation of an NxN image
// (N = 4/8/16/32, clamped to MAX_DIM) with a 3x3 template. Results are
// streamed serially MSB first, in raster order, with no gaps between them.
// Optional macro: TMIP_XCORR_SIGNED_TPL_EN (signed template coefficients,
// signed results); timing is identical with or without it.
module tmip_xcorr_engine
  import tmip_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int MAX_DIM = 16,
  parameter int OUT_W   = tmip_out_w(PIX_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [PIX_W-1:0] i_image,
  input  logic [PIX_W-1:0] i_template,
  input  logic [1:0]       i_image_size,
  output logic             o_out_valid,
  output logic             o_out_value
);

  localparam int DW = $clog2(MAX_DIM);   // row/column index width
  localparam int AW = 2 * DW;            // pixel address width
  localparam int CW = AW + 1;            // load counter width (holds N*N)
  localparam int BW = $clog2(OUT_W);     // bit counter width

  localparam logic [2:0]    LG_MAX   = 3'(DW);
  localparam logic [DW:0]   N_ONE    = {{DW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] RC_ONE   = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TPL_TAPS = CW'(9);
  localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_LAST = BW'(OUT_W - 1);

  // Storage (no reset needed)
  logic [PIX_W-1:0] r_img [MAX_DIM*MAX_DIM];
  logic [PIX_W-1:0] r_tpl [9];

  // Control state
  tmip_state_t      r_state;
  logic [2:0]       r_lg;      // log2 of the latched side length
  logic [CW-1:0]    r_cnt;     // pixels received so far in LOAD
  logic [DW-1:0]    r_row;     // position of the next result to compute
  logic [DW-1:0]    r_col;
  logic             r_done;    // result currently being emitted is the last one
  logic [BW-1:0]    r_bit;     // bit index within the current result
  logic [OUT_W-2:0] r_sh;      // remaining bits of the current result

  logic [2:0]         w_lg_req;
  logic [2:0]         w_lg_dec;
  logic [DW:0]        w_n;
  logic [CW-1:0]      w_nn;
  logic               w_img_we;
  logic               w_tpl_we;
  logic [AW-1:0]      w_img_addr;
  logic [3:0]         w_tpl_addr;
  logic [DW:0]        w_rr [3];
  logic [DW:0]        w_cc [3];
  logic [9*PIX_W-1:0] w_pix_bus;
  logic [9*PIX_W-1:0] w_coef_bus;
  logic [8:0]         w_mask;
  logic [OUT_W-1:0]   w_sum;
  logic               w_col_last;
  logic               w_row_last;
  logic [DW-1:0]      w_row_nxt;
  logic [DW-1:0]      w_col_nxt;
  logic               w_done_nxt;

  assign w_n  = N_ONE << r_lg;
  assign w_nn = C_ONE << {r_lg, 1'b0};

  // Decode the side selector to log2(N), clamped to the largest supported side
  always_comb begin
    case (i_image_size)
      SZ_4:    w_lg_req = 3'd2;
      SZ_8:    w_lg_req = 3'd3;
      SZ_16:   w_lg_req = 3'd4;
      SZ_32:   w_lg_req = 3'd5;
      default: w_lg_req = 3'd2;
    endcase
    if (w_lg_req > LG_MAX) begin
      w_lg_dec = LG_MAX;
    end else begin
      w_lg_dec = w_lg_req;
    end
  end

  // Route the incoming pixel/coefficient to storage; excess pixels are dropped
  always_comb begin
    w_img_we   = 1'b0;
    w_tpl_we   = 1'b0;
    w_img_addr = {AW{1'b0}};
    w_tpl_addr = 4'd0;
    if (r_state == IDLE) begin
      w_img_we = i_in_valid;
      w_tpl_we = i_in_valid;
    end else if (r_state == LOAD) begin
      w_img_we   = i_in_valid && (r_cnt < w_nn);
      w_tpl_we   = i_in_valid && (r_cnt < TPL_TAPS);
      w_img_addr = r_cnt[AW-1:0];
      w_tpl_addr = r_cnt[3:0];
    end else begin
      w_img_we = 1'b0;
      w_tpl_we = 1'b0;
    end
  end

  // Image and template storage
  always_ff @(posedge clk) begin
    if (w_img_we) begin
      r_img[w_img_addr] <= i_image;
    end
    if (w_tpl_we) begin
      r_tpl[w_tpl_addr] <= i_template;
    end
  end

  // Gather the 3x3 neighbourhood of (r_row, r_col); taps outside the image are masked.
  // Off-image rows/cols wrap to values >= N in DW+1 bits, so one compare covers both edges.
  always_comb begin
    logic [AW-1:0] v_addr;
    v_addr     = {AW{1'b0}};
    w_pix_bus  = {(9*PIX_W){1'b0}};
    w_coef_bus = {(9*PIX_W){1'b0}};
    w_mask     = 9'd0;
    w_rr[0] = {1'b0, r_row} - N_ONE;
    w_rr[1] = {1'b0, r_row};
    w_rr[2] = {1'b0, r_row} + N_ONE;
    w_cc[0] = {1'b0, r_col} - N_ONE;
    w_cc[1] = {1'b0, r_col};
    w_cc[2] = {1'b0, r_col} + N_ONE;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v_addr = (AW'(w_rr[i][DW-1:0]) << r_lg) | AW'(w_cc[j][DW-1:0]);
        w_mask[i*3+j] = (w_rr[i] < w_n) && (w_cc[j] < w_n);
        w_pix_bus[(i*3+j)*PIX_W +: PIX_W]  = r_img[v_addr];
        w_coef_bus[(i*3+j)*PIX_W +: PIX_W] = r_tpl[i*3+j];
      end
    end
  end

  tmip_mac9 #(
    .PIX_W (PIX_W),
    .OUT_W (OUT_W)
  ) u_mac9 (
    .i_pix  (w_pix_bus),
    .i_mask (w_mask),
    .i_coef (w_coef_bus),
    .o_sum  (w_sum)
  );

  // Raster step to the following result position; flags the final one
  always_comb begin
    w_col_last = ({1'b0, r_col} == (w_n - N_ONE));
    w_row_last = ({1'b0, r_row} == (w_n - N_ONE));
    if (w_col_last) begin
      w_col_nxt = {DW{1'b0}};
      if (w_row_last) begin
        w_row_nxt  = r_row;
        w_done_nxt = 1'b1;
      end else begin
        w_row_nxt  = r_row + RC_ONE;
        w_done_nxt = 1'b0;
      end
    end else begin
      w_col_nxt  = r_col + RC_ONE;
      w_row_nxt  = r_row;
      w_done_nxt = 1'b0;
    end
  end

  // Control FSM: load image, compute first result, then serialise all results back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lg        <= 3'd2;
      r_cnt       <= {CW{1'b0}};
      r_row       <= {DW{1'b0}};
      r_col       <= {DW{1'b0}};
      r_done      <= 1'b0;
      r_bit       <= {BW{1'b0}};
      r_sh        <= {(OUT_W-1){1'b0}};
      o_out_valid <= 1'b0;
      o_out_value <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_out_valid <= 1'b0;
          o_out_value <= 1'b0;
          if (i_in_valid) begin
            r_lg    <= w_lg_dec;
            r_cnt   <= C_ONE;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (i_in_valid) begin
            if (r_cnt < w_nn) begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
            r_cnt   <= {CW{1'b0}};
            r_row   <= {DW{1'b0}};
            r_col   <= {DW{1'b0}};
            r_done  <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          o_out_valid <= 1'b1;
          o_out_value <= w_sum[OUT_W-1];
          r_sh        <= w_sum[OUT_W-2:0];
          r_bit       <= {BW{1'b0}};
          r_row       <= w_row_nxt;
          r_col       <= w_col_nxt;
          r_done      <= w_done_nxt;
          r_state     <= OUT;
        end
        OUT: begin
          if (r_bit == BIT_LAST) begin
            if (r_done) begin
              o_out_valid <= 1'b0;
              o_out_value <= 1'b0;
              r_sh        <= {(OUT_W-1){1'b0}};
              r_bit       <= {BW{1'b0}};
              r_done      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              o_out_value <= w_sum[OUT_W-1];
              r_sh        <= w_sum[OUT_W-2:0];
              r_bit       <= {BW{1'b0}};
              r_row       <= w_row_nxt;
              r_col       <= w_col_nxt;
              r_done      <= w_done_nxt;
            end
          end else begin
            o_out_value <= r_sh[OUT_W-2];
            r_sh        <= {r_sh[OUT_W-3:0], 1'b0};
            r_bit       <= r_bit + BIT_ONE;
          end
        end
        default: begin
          o_out_valid <= 1'b0;
          o_out_value <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmip_xcorr_engine.sv
// tb_tmip_xcorr_engine: directed self-checking bench for tmip_xcorr_engine.
// A behavioural model computes every correlation result from the fed pixels
// and template with plain integer arithmetic; the stream checker compares
// every emitted bit, out_valid, latency and idle behaviour against it.
module tb_tmip_xcorr_engine;

  localparam int PIX_W   = 8;
  localparam int MAX_DIM = 16;
  localparam int OUT_W   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] image_in = 8'd0;
  logic [7:0] tpl_in = 8'd0;
  logic [1:0] image_size = 2'd0;
  logic       out_valid;
  logic       out_value;

  tmip_xcorr_engine #(
    .PIX_W   (PIX_W),
    .MAX_DIM (MAX_DIM),
    .OUT_W   (OUT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .i_image      (image_in),
    .i_template   (tpl_in),
    .i_image_size (image_size),
    .o_out_valid  (out_valid),
    .o_out_value  (out_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int pix_q [1024];
  int tpl_m [9];
  int exp_r [256];
  int got_r [256];
  int n_m = 4;
  int last_samp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pix_gen(input int mode, input int k, input int v);
    if (mode == 0) return v;
    if (mode == 1) return k % 256;
    if (mode == 2) return (k < 256) ? k : ((k * 7 + 3) % 256);
    return (k * 13 + 5) % 256;
  endfunction

  function automatic int coef(input int t);
`ifdef TMIP_XCORR_SIGNED_TPL_EN
    return (t >= 128) ? t - 256 : t;
`else
    return t;
`endif
  endfunction

  // Reference: zero-padded 3x3 correlation over the first N*N fed pixels
  task automatic model(input int sel);
    n_m = 4 << sel;
    if (n_m > MAX_DIM) n_m = MAX_DIM;
    for (int r = 0; r < n_m; r++) begin
      for (int c = 0; c < n_m; c++) begin
        int s;
        s = 0;
        for (int i = -1; i <= 1; i++) begin
          for (int j = -1; j <= 1; j++) begin
            if (r + i >= 0 && r + i < n_m && c + j >= 0 && c + j < n_m)
              s += pix_q[(r + i) * n_m + (c + j)] * coef(tpl_m[(i + 1) * 3 + (j + 1)]);
          end
        end
        exp_r[r * n_m + c] = s;
      end
    end
  endtask

  task automatic set_tpl(input int t0, input int t1, input int t2, input int t3, input int t4,
                         input int t5, input int t6, input int t7, input int t8);
    tpl_m = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
  endtask

  // Drive one burst starting at the current negedge; checks outputs stay idle while loading
  task automatic feed(input int sel, input int npix, input int mode, input int v);
    for (int k = 0; k < npix; k++) begin
      int pv;
      pv = pix_gen(mode, k, v);
      pix_q[k] = pv;
      in_valid   = 1'b1;
      image_in   = 8'(pv);
      image_size = (k == 0) ? 2'(sel) : 2'(~sel);
      tpl_in     = (k < 9) ? 8'(tpl_m[k]) : 8'($urandom_range(255, 0));
      @(negedge clk);
      check("load_out_idle", {30'd0, out_valid, out_value}, 32'd0);
    end
    in_valid  = 1'b0;
    image_in  = 8'd0;
    tpl_in    = 8'd0;
    last_samp = cyc;
  endtask

  // Wait for the stream, then compare every bit and the falling edge against the model
  task automatic stream(input bit noise);
    bit found;
    int high;
    found = 1'b0;
    high  = 0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      check("pre_out_value", {31'd0, out_value}, 32'd0);
    end
    check("first_out_valid", {31'd0, found}, 32'd1);
    if (!found) return;
    check("latency", cyc - last_samp, 32'd2);
    for (int idx = 0; idx < n_m * n_m; idx++) begin
      logic [31:0] word;
      int exp_w;
      word  = 32'd0;
      exp_w = exp_r[idx] & 32'hFFFFF;
      for (int b = OUT_W - 1; b >= 0; b--) begin
        check($sformatf("out_valid r%0d b%0d", idx, b), {31'd0, out_valid}, 32'd1);
        check($sformatf("bit r%0d b%0d", idx, b), {31'd0, out_value}, (exp_w >> b) & 1);
        word = {word[30:0], out_value};
        if (out_valid) high++;
        in_valid = noise && ((idx * OUT_W + (OUT_W - 1 - b)) < 39);
        image_in = 8'($urandom_range(255, 0));
        @(negedge clk);
      end
      got_r[idx] = word;
    end
    in_valid = 1'b0;
    check("out_fall", {30'd0, out_valid, out_value}, 32'd0);
    check("high_cycles", high, n_m * n_m * OUT_W);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {30'd0, out_valid, out_value}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 all ones, template all ones; in_valid noise during OUT must be ignored
    set_tpl(1, 1, 1, 1, 1, 1, 1, 1, 1);
    feed(0, 16, 0, 1);
    model(0);
    check("model_corner", exp_r[0], 32'd4);
    check("model_edge", exp_r[1], 32'd6);
    check("model_interior", exp_r[5], 32'd9);
    check("model_corner_last", exp_r[15], 32'd4);
    stream(1'b1);
    check("first_word", got_r[0], 32'h00004);
    check("interior_word", got_r[10], 32'd9);

    // 4x4 all 255 with template all 255: maximum-magnitude sums
    set_tpl(255, 255, 255, 255, 255, 255, 255, 255, 255);
    feed(0, 16, 0, 255);
    model(0);
`ifndef TMIP_XCORR_SIGNED_TPL_EN
    check("model_max", exp_r[5], 32'd585225);
    check("model_max_corner", exp_r[0], 32'd260100);
`endif
    stream(1'b0);
`ifndef TMIP_XCORR_SIGNED_TPL_EN
    check("max_word", got_r[5], 32'h8EE09);
    check("max_corner_word", got_r[0], 32'h3F804);
`endif

    // 16x16 ramp with identity template
    set_tpl(0, 0, 0, 0, 1, 0, 0, 0, 0);
    feed(2, 256, 1, 0);
    model(2);
    check("model_identity", exp_r[37], 32'd37);
    stream(1'b0);
    check("identity_37", got_r[37], 32'd37);
    check("identity_255", got_r[255], 32'd255);

    // Size code 3 clamps to 16x16; pixels past 256 differ and must be discarded
    feed(3, 1024, 2, 0);
    model(3);
    stream(1'b0);
    check("clamp_200", got_r[200], 32'd200);

    // 8x8 with distinct weights checks tap ordering
    set_tpl(1, 2, 3, 4, 5, 6, 7, 8, 9);
    feed(1, 64, 3, 0);
    model(1);
    stream(1'b0);

    // Reset in the middle of OUT, then a normal 4x4 image
    set_tpl(255, 255, 255, 255, 255, 255, 255, 255, 255);
    feed(0, 16, 0, 255);
    begin
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("reset_test_start", {31'd0, seen}, 32'd1);
    end
    repeat (3) @(negedge clk);
`ifndef TMIP_XCORR_SIGNED_TPL_EN
    check("pre_reset_bit", {31'd0, out_value}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("reset_mid_out", {30'd0, out_valid, out_value}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {30'd0, out_valid, out_value}, 32'd0);
    set_tpl(1, 1, 1, 1, 1, 1, 1, 1, 1);
    feed(0, 16, 0, 1);
    model(0);
    stream(1'b0);
    check("post_reset_word", got_r[0], 32'h00004);

`ifdef TMIP_XCORR_SIGNED_TPL_EN
    // Signed template: all -128 against all-255 pixels
    set_tpl(128, 128, 128, 128, 128, 128, 128, 128, 128);
    feed(0, 16, 0, 255);
    model(0);
    check("model_signed", exp_r[5], -32'sd293760);
    check("model_signed_20b", exp_r[5] & 32'hFFFFF, 32'hB8480);
    stream(1'b0);
    check("signed_word", got_r[5], 32'hB8480);
`endif

    // Mixed-sign-bit template, started right after the previous out_valid fell
    set_tpl(255, 1, 2, 3, 4, 5, 6, 7, 240);
    feed(0, 16, 1, 0);
    model(0);
    stream(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmip_xcorr_engine.md
Name: tmip_xcorr_engine

Overview:
- Parametrised successor of the TMIP cross-correlation path.
- Accepts one grayscale image of run-time-selectable size (4x4 / 8x8 / 16x16, up to MAX_DIM), plus a 3x3 template.
- Computes the zero-padded 3x3 cross-correlation at every pixel position.
- Streams each result serially, MSB first, on a single-bit output.
- Sits after the grayscale/transform stage; it is a standalone engine with its own input/output handshake.

Parameters:
- PIX_W, 8: pixel and template coefficient width.
- MAX_DIM, 16: largest supported image side; must be a power of 2, 4..32.
- OUT_W, 2*PIX_W+4: width of each serialised result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  high for exactly N*N consecutive cycles per image.
- image  in  PIX_W  pixel, raster order, one per in_valid cycle.
- template  in  PIX_W  coefficient, raster order; valid on the first 9 in_valid cycles only.
- image_size  in  2  side selector; sampled on the first in_valid cycle only. 0=4, 1=8, 2=16, 3=32.
- out_valid  out  1  high while result bits are being emitted.
- out_value  out  1  current result bit, MSB first.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out_value=0, FSM=IDLE, all counters 0. Stored image and template need no reset.
- Size decode:
  - N = 4 << image_size.
  - If N > MAX_DIM, N is clamped to MAX_DIM.
  - Pixels beyond the clamped N*N count are discarded.
- FSM states and transitions:
  - IDLE -> LOAD on the first in_valid=1 cycle.
  - LOAD: stores pixel k at raster address k, and template coefficient k for k<9. LOAD -> CALC when in_valid falls.
  - CALC: one cycle. Computes result(0,0) and loads it into the OUT_W shift register. CALC -> OUT.
  - OUT: out_valid=1 continuously for exactly N*N*OUT_W cycles, emitting shift-register bits MSB first.
    - In the last bit cycle of each result, the next result is loaded, so there is no gap between results.
    - After the final bit of result(N-1,N-1): out_valid=0 and out_value=0 on the following cycle. OUT -> IDLE.
- Latency: first out_valid=1 occurs exactly 2 cycles after the last in_valid=1 cycle.
- Result definition:
  - R(r,c) = sum over i,j in {-1,0,1} of P(r+i,c+j) * T(i+1,j+1).
  - P outside 0..N-1 is 0 (zero padding).
  - Products are unsigned PIX_W x PIX_W; the sum is OUT_W bits and never overflows (9*255*255 = 585225 < 2^20).
- Output order: results emitted in raster order (r outer, c inner).
- Handshake rules:
  - in_valid asserted during CALC or OUT is ignored; it does not restart the engine.
  - A new image is accepted only from IDLE.
  - A new in_valid may rise in the cycle immediately after out_valid falls.
- out_value is 0 whenever out_valid=0.
- Reset mid-operation: in any state, rst_n=0 returns the engine to IDLE with outputs 0 immediately. Partially loaded data is abandoned.
- Short burst (fewer than N*N in_valid cycles): unspecified pixels read as their last stored value. The engine still emits N*N results; the bench must not rely on their values.

Optional Feature:
- Macro: TMIP_XCORR_SIGNED_TPL_EN.
- Defined: template coefficients are two's-complement signed PIX_W. Pixels stay unsigned. R is a signed OUT_W two's-complement value, and emission is still MSB (sign bit) first. Range for PIX_W=8: -293760..291465, which fits in 20 bits.
- Undefined: template is unsigned and R is unsigned; timing is identical in both cases.

Decomposition:
- Package tmip_pkg:
  - Image-size encoding constants: SZ_4, SZ_8, SZ_16, SZ_32.
  - FSM state typedef: IDLE, LOAD, CALC, OUT.
  - A function returning the default OUT_W from PIX_W.
- Sub-module tmip_mac9: purely combinational.
  - Inputs: nine pixels with padding masks, and nine coefficients.
  - Output: the OUT_W sum.
  - Contains the signed/unsigned selection under the macro.
- The top holds the storage, FSM, address counters and serializer.

Test Plan:
- 4x4, all pixels 1, template all 1 -> results:
  - corners = 4, edges = 6, interior = 9.
  - First 20 bits = 0x00004, MSB first.
  - out_valid high for exactly 320 cycles.
- 4x4, all pixels 255, template all 255 -> R(1,1) = 585225 (0x8EE09); corners = 260100 (0x3F804).
- 16x16, pixel(k) = k mod 256, template = identity (centre 1, others 0) -> R(r,c) = pixel(r,c) for all 256 results; 5120 out_valid cycles; latency = 2 cycles.
- image_size=3 with MAX_DIM=16 -> treated as 16x16. Feed 1024 pixels: only the first 256 are used, and 256 results are emitted.
- Reset pulse in the middle of OUT -> out_valid=0 and out_value=0 in the same cycle. A following 4x4 image is processed correctly with the normal latency.
- With TMIP_XCORR_SIGNED_TPL_EN: 4x4 all 255, template all 0x80 (-128) -> R(1,1) = -293760 = 0xB8480 (20-bit). Back-to-back second image accepted immediately after out_valid falls.
